// File: rtl/wb_uart_fifo_slave.sv
// -----------------------------------------------------------------------------
// wb_uart_fifo_slave
//
// This is a Wishbone pipelined slave that connects a byte-level UART
// transmitter/receiver pair to the system bus. A FIFO buffers each direction.
// The slave exposes four word registers:
//   0 DATA      : read pops the RX FIFO; write pushes to the TX FIFO
//   1 STATUS    : FIFO state, sticky overflow flags (write 1 to clear), counts
//   2 IRQ_EN    : [0] RX-threshold enable, [1] TX-idle-and-empty enable
//   3 RX_THRESH : RX count at or above which the RX interrupt term is true
//
// Ports (clk_bus domain only; rst_bus_n asserts asynchronously, active-low):
//   adr_i/dat_i/sel_i/cyc_i/stb_i/we_i   Wishbone request
//   dat_o/ack_o/err_o/rty_o/stall_o      Wishbone response (rty/stall are 0)
//   tx_data/tx_start/tx_busy             UART transmitter handshake
//   rx_data/rx_ready/rx_clear            UART receiver handshake
//   irq/irq_permitted                    level interrupt, gated by the PLIC
// -----------------------------------------------------------------------------

// Circular byte FIFO with show-ahead read data. A push is accepted when the
// FIFO is not full, or when a pop happens in the same cycle.
module wb_uart_fifo_slave_fifo #(
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_push_ok
);
    localparam int           DEPTH   = 1 << AW;
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];

    // A pop frees a slot at the same edge, so a full FIFO can still take a push.
    assign w_pop     = i_pop & ~o_empty;
    assign w_push    = i_push & (~o_full | w_pop);
    assign o_push_ok = w_push;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module wb_uart_fifo_slave #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic        clk_bus,
    input  logic        rst_bus_n,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        stall_o,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_clear,
    output logic        irq,
    input  logic        irq_permitted
);
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO
    } tx_state_t;

    // Bus decode
    logic        w_req;
    logic        w_align_ok;
    logic        w_acc;
    logic        w_bad;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_reg;
    logic [31:0] w_rdata;
    logic [31:0] w_status;

    // FIFO hookup
    logic           w_rx_in;
    logic           w_rx_pop;
    logic           w_rx_push_ok;
    logic [7:0]     w_rx_rdata;
    logic [RX_AW:0] w_rx_count;
    logic           w_rx_full;
    logic           w_rx_empty;
    logic           w_tx_push;
    logic           w_tx_push_ok;
    logic [7:0]     w_tx_rdata;
    logic [TX_AW:0] w_tx_count;
    logic           w_tx_full;
    logic           w_tx_empty;
    logic           w_tx_idle_empty;

    // TX FSM
    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic        w_tx_pop;
    logic        w_tx_start;

    // Registers
    logic [31:0]    r_dat;
    logic           r_ack;
    logic           r_err;
    logic [7:0]     r_tx_data;
    logic           r_rx_clear;
    logic           r_rx_ovr;
    logic           r_tx_ovf;
    logic [1:0]     r_irq_en;
    logic [RX_AW:0] r_rx_thresh;
    logic           r_irq;
    logic           w_irq_next;

    // Bits with no function in this register map.
    logic w_unused_bits;
    assign w_unused_bits = ^{adr_i[31:4], dat_i[31:8], sel_i[3:1]};

    assign w_req      = cyc_i & stb_i;
    assign w_align_ok = (adr_i[1:0] == 2'b00);
    assign w_acc      = w_req & w_align_ok;
    assign w_bad      = w_req & ~w_align_ok;
    assign w_rd       = w_acc & ~we_i;
    assign w_wr       = w_acc & we_i & sel_i[0];
    assign w_reg      = adr_i[3:2];

    // ---------------- RX path ----------------
    // While rx_clear is high the receiver is still seeing our previous
    // acknowledge, so rx_ready is ignored for that cycle.
    assign w_rx_in  = rx_ready & ~r_rx_clear;
    assign w_rx_pop = w_rd & (w_reg == REG_DATA);

    wb_uart_fifo_slave_fifo #(
        .AW (RX_AW)
    ) u_rx_fifo (
        .i_clk     (clk_bus),
        .i_rst_n   (rst_bus_n),
        .i_push    (w_rx_in),
        .i_pop     (w_rx_pop),
        .i_wdata   (rx_data),
        .o_rdata   (w_rx_rdata),
        .o_count   (w_rx_count),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_push_ok (w_rx_push_ok)
    );

    // ---------------- TX path ----------------
    assign w_tx_push = w_wr & (w_reg == REG_DATA);

    wb_uart_fifo_slave_fifo #(
        .AW (TX_AW)
    ) u_tx_fifo (
        .i_clk     (clk_bus),
        .i_rst_n   (rst_bus_n),
        .i_push    (w_tx_push),
        .i_pop     (w_tx_pop),
        .i_wdata   (dat_i[7:0]),
        .o_rdata   (w_tx_rdata),
        .o_count   (w_tx_count),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_push_ok (w_tx_push_ok)
    );

    assign w_tx_idle_empty = w_tx_empty & (r_state == ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        w_tx_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_tx_empty && !tx_busy) begin
                    w_tx_pop     = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_start   = 1'b1;
                w_state_next = ST_WAIT_HI;
            end
            // The transmitter has to show a full busy high-low cycle before the
            // next byte goes out; a start pulse alone is not taken as completion.
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    w_state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_bus or negedge rst_bus_n) begin
        if (!rst_bus_n) begin
            r_state   <= ST_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tx_pop) begin
                r_tx_data <= w_tx_rdata;
            end
        end
    end

    // ---------------- Register read mux (pre-edge state) ----------------
    always_comb begin
        w_status        = '0;
        w_status[0]     = ~w_rx_empty;
        w_status[1]     = ~w_tx_full;
        w_status[2]     = w_tx_idle_empty;
        w_status[3]     = r_rx_ovr;
        w_status[4]     = r_tx_ovf;
        w_status[15:8]  = 8'(w_rx_count);
        w_status[23:16] = 8'(w_tx_count);
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA:   w_rdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_rdata};
            REG_STATUS: w_rdata = w_status;
            REG_IRQ_EN: w_rdata = {30'd0, r_irq_en};
            REG_THRESH: w_rdata = 32'(r_rx_thresh);
            default:    w_rdata = '0;
        endcase
    end

    // A threshold of zero always satisfies the comparison, so the RX term is
    // then permanently true while enabled.
    assign w_irq_next = irq_permitted &
                        ((r_irq_en[0] & (w_rx_count >= r_rx_thresh)) |
                         (r_irq_en[1] & w_tx_idle_empty));

    // ---------------- Bus response, control registers, flags ----------------
    always_ff @(posedge clk_bus or negedge rst_bus_n) begin
        if (!rst_bus_n) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= '0;
            r_rx_clear  <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_irq_en    <= '0;
            r_rx_thresh <= (RX_AW + 1)'(1);
            r_irq       <= 1'b0;
        end else begin
            r_ack      <= w_acc;
            r_err      <= w_bad;
            r_dat      <= w_rd ? w_rdata : 32'd0;
            r_rx_clear <= w_rx_in;
            r_irq      <= w_irq_next;

            if (w_wr && (w_reg == REG_IRQ_EN)) begin
                r_irq_en <= dat_i[1:0];
            end
            if (w_wr && (w_reg == REG_THRESH)) begin
                r_rx_thresh <= dat_i[RX_AW:0];
            end

            // A new overflow in the same cycle as a clear wins, so no event is lost.
            if (w_rx_in && !w_rx_push_ok) begin
                r_rx_ovr <= 1'b1;
            end else if (w_wr && (w_reg == REG_STATUS) && dat_i[3]) begin
                r_rx_ovr <= 1'b0;
            end
            if (w_tx_push && !w_tx_push_ok) begin
                r_tx_ovf <= 1'b1;
            end else if (w_wr && (w_reg == REG_STATUS) && dat_i[4]) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end

    assign dat_o    = r_dat;
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign rty_o    = 1'b0;
    assign stall_o  = 1'b0;
    assign tx_data  = r_tx_data;
    assign tx_start = w_tx_start;
    assign rx_clear = r_rx_clear;
    assign irq      = r_irq;
endmodule

// File: tb/tb_wb_uart_fifo_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_fifo_slave
//
// Testbench for wb_uart_fifo_slave. A table of register accesses with
// expected responses is applied first. Hand-written sequences follow for the
// loopback, overflow, interrupt, simultaneous-event and mid-transfer reset
// cases. Each bus transaction prints one line.
// -----------------------------------------------------------------------------
module tb_wb_uart_fifo_slave;
    logic        clk_bus       = 1'b0;
    logic        rst_bus_n     = 1'b1;
    logic [31:0] adr_i         = '0;
    logic [31:0] dat_i         = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i         = '0;
    logic        cyc_i         = 1'b0;
    logic        stb_i         = 1'b0;
    logic        we_i          = 1'b0;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic        stall_o;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy       = 1'b0;
    logic [7:0]  rx_data       = '0;
    logic        rx_ready      = 1'b0;
    logic        rx_clear;
    logic        irq;
    logic        irq_permitted = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    wb_uart_fifo_slave #(
        .RX_AW (4),
        .TX_AW (4)
    ) dut (
        .clk_bus       (clk_bus),
        .rst_bus_n     (rst_bus_n),
        .adr_i         (adr_i),
        .dat_i         (dat_i),
        .dat_o         (dat_o),
        .sel_i         (sel_i),
        .cyc_i         (cyc_i),
        .stb_i         (stb_i),
        .we_i          (we_i),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .rty_o         (rty_o),
        .stall_o       (stall_o),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_clear      (rx_clear),
        .irq           (irq),
        .irq_permitted (irq_permitted)
    );

    always #5 clk_bus = ~clk_bus;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic ack, output logic err,
                       output logic [31:0] rdat);
        @(negedge clk_bus);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        @(posedge clk_bus);
        #1;
        ack = ack_o; err = err_o; rdat = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        $display("txn we=%0d adr=%h wdat=%h sel=%h -> ack=%0d err=%0d rdat=%h",
                 we, adr, dat, sel, ack, err, rdat);
    endtask

    task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic a, e;
        logic [31:0] d;
        bus(1'b0, adr, 32'd0, 4'hF, a, e, d);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
        chk(name, d, exp);
    endtask

    task automatic wr(input string name, input logic [31:0] adr, input logic [31:0] dat);
        logic a, e;
        logic [31:0] d;
        bus(1'b1, adr, dat, 4'hF, a, e, d);
        chk({name, "_ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk_bus);
        rx_ready = 1'b1; rx_data = b;
        @(posedge clk_bus);
        #1;
        rx_ready = 1'b0;
        chk("rx_clear_pulse", {31'd0, rx_clear}, 32'd1);
        @(posedge clk_bus);
        #1;
        chk("rx_clear_drop", {31'd0, rx_clear}, 32'd0);
    endtask

    task automatic wait_tx_start(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_bus);
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_bus);
        rst_bus_n = 1'b0;
        tx_busy = 1'b0; rx_ready = 1'b0; irq_permitted = 1'b0;
        repeat (2) @(negedge clk_bus);
        rst_bus_n = 1'b1;
    endtask

    initial begin
        logic a, e;
        logic [31:0] d;

        // Register accesses with irq_permitted low and the transmitter idle
        vecs[0]  = '{1'b0, 32'h4, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0000_0006};
        vecs[1]  = '{1'b0, 32'h8, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'hC, 32'h0,        4'hF, 1'b1, 1'b0, 32'h1};
        vecs[3]  = '{1'b0, 32'h0, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h4, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0000_0006};
        vecs[5]  = '{1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h8, 32'h0,        4'hF, 1'b1, 1'b0, 32'h3};
        vecs[7]  = '{1'b1, 32'h8, 32'h0,        4'hE, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h8, 32'h0,        4'hF, 1'b1, 1'b0, 32'h3};
        vecs[9]  = '{1'b1, 32'h8, 32'h0,        4'h1, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h8, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'hC, 32'h25,       4'h1, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'hC, 32'h0,        4'hF, 1'b1, 1'b0, 32'h5};
        vecs[13] = '{1'b1, 32'hC, 32'h1,        4'hF, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'hC, 32'h0,        4'hF, 1'b1, 1'b0, 32'h1};
        vecs[15] = '{1'b0, 32'h2, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 32'h9, 32'h3,        4'hF, 1'b0, 1'b1, 32'h0};
        vecs[17] = '{1'b0, 32'h8, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 32'h0, 32'h77,       4'hE, 1'b1, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 32'h4, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0000_0006};

        // ---------------- Reset values ----------------
        #1 rst_bus_n = 1'b0;
        #12;
        chk("rst_ack",      {31'd0, ack_o},    32'd0);
        chk("rst_err",      {31'd0, err_o},    32'd0);
        chk("rst_dat",      dat_o,             32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("rst_rx_clear", {31'd0, rx_clear}, 32'd0);
        chk("rst_irq",      {31'd0, irq},      32'd0);
        chk("rst_rty_stall", {30'd0, rty_o, stall_o}, 32'd0);
        @(negedge clk_bus);
        rst_bus_n = 1'b1;

        // ---------------- Table-driven register accesses ----------------
        for (int i = 0; i < NVEC; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a, e, d);
            chk($sformatf("vec%0d_ack", i), {31'd0, a}, {31'd0, vecs[i].exp_ack});
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            if (vecs[i].exp_ack && !vecs[i].we) begin
                chk($sformatf("vec%0d_dat", i), d, vecs[i].exp_dat);
            end
        end
        // The ack lasts exactly one cycle.
        @(posedge clk_bus);
        #1;
        chk("ack_one_cycle", {31'd0, ack_o}, 32'd0);

        // ---------------- Loopback ----------------
        wr("lb_wr41", 32'h0, 32'h41);
        wr("lb_wr42", 32'h0, 32'h42);
        wait_tx_start("lb_start1_seen");
        chk("lb_data1", {24'd0, tx_data}, 32'h41);
        @(negedge clk_bus);
        chk("lb_start1_len", {31'd0, tx_start}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_bus);
            chk("lb_hold_before_busy", {31'd0, tx_start}, 32'd0);
        end
        tx_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_bus);
            chk("lb_hold_while_busy", {31'd0, tx_start}, 32'd0);
        end
        tx_busy = 1'b0;
        wait_tx_start("lb_start2_seen");
        chk("lb_data2", {24'd0, tx_data}, 32'h42);
        @(negedge clk_bus);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk_bus);
        tx_busy = 1'b0;
        rd("lb_status_end", 32'h4, 32'h0000_0006);

        // ---------------- RX overflow ----------------
        for (int i = 0; i < 17; i++) begin
            rx_byte(8'(i));
        end
        rd("rxo_status", 32'h4, 32'h0000_100F);
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("rxo_pop%0d", i), 32'h0, 32'(i));
        end
        rd("rxo_pop_empty", 32'h0, 32'h0);
        rd("rxo_status_empty", 32'h4, 32'h0000_000E);
        wr("rxo_clear", 32'h4, 32'h08);
        rd("rxo_status_clr", 32'h4, 32'h0000_0006);

        // ---------------- TX overflow ----------------
        wr("txo_wr0", 32'h0, 32'h80);
        wait_tx_start("txo_start_seen");
        tx_busy = 1'b1;
        chk("txo_data", {24'd0, tx_data}, 32'h80);
        for (int i = 1; i < 18; i++) begin
            wr($sformatf("txo_wr%0d", i), 32'h0, 32'h80 + 32'(i));
        end
        rd("txo_status", 32'h4, 32'h0010_0010);
        wr("txo_clear", 32'h4, 32'h10);
        rd("txo_status_clr", 32'h4, 32'h0010_0000);
        do_reset();

        // ---------------- Interrupt gating ----------------
        wr("irq_thresh", 32'hC, 32'h3);
        wr("irq_en", 32'h8, 32'h1);
        irq_permitted = 1'b1;
        rx_byte(8'h11);
        rx_byte(8'h22);
        chk("irq_below_thresh", {31'd0, irq}, 32'd0);
        rx_byte(8'h33);
        chk("irq_at_thresh", {31'd0, irq}, 32'd1);
        @(negedge clk_bus);
        irq_permitted = 1'b0;
        @(negedge clk_bus);
        chk("irq_not_permitted", {31'd0, irq}, 32'd0);
        irq_permitted = 1'b1;
        @(negedge clk_bus);
        chk("irq_permitted_again", {31'd0, irq}, 32'd1);
        rd("irq_pop", 32'h0, 32'h11);
        chk("irq_at_ack", {31'd0, irq}, 32'd1);
        @(posedge clk_bus);
        #1;
        chk("irq_after_ack", {31'd0, irq}, 32'd0);
        rd("irq_pop2", 32'h0, 32'h22);
        rd("irq_pop3", 32'h0, 32'h33);
        wr("irq_thresh0", 32'hC, 32'h0);
        @(posedge clk_bus);
        #1;
        chk("irq_thresh0_empty", {31'd0, irq}, 32'd1);
        wr("irq_en_off", 32'h8, 32'h0);
        @(posedge clk_bus);
        #1;
        chk("irq_disabled", {31'd0, irq}, 32'd0);
        do_reset();

        // ---------------- Simultaneous push/pop on a full RX FIFO, errors ----------------
        for (int i = 0; i < 16; i++) begin
            rx_byte(8'hA0 + 8'(i));
        end
        @(negedge clk_bus);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0; sel_i = 4'hF;
        rx_ready = 1'b1; rx_data = 8'hEE;
        @(posedge clk_bus);
        #1;
        $display("txn we=0 adr=00000000 with rx_ready -> ack=%0d err=%0d rdat=%h", ack_o, err_o, dat_o);
        chk("sim_ack", {31'd0, ack_o}, 32'd1);
        chk("sim_dat", dat_o, 32'h0000_00A0);
        chk("sim_rx_clear", {31'd0, rx_clear}, 32'd1);
        cyc_i = 1'b0; stb_i = 1'b0; rx_ready = 1'b0;
        @(posedge clk_bus);
        rd("sim_status", 32'h4, 32'h0000_1007);
        bus(1'b0, 32'h2, 32'h0, 4'hF, a, e, d);
        chk("err_rd_ack", {31'd0, a}, 32'd0);
        chk("err_rd_err", {31'd0, e}, 32'd1);
        bus(1'b1, 32'h2, 32'h55, 4'hF, a, e, d);
        chk("err_wr_ack", {31'd0, a}, 32'd0);
        chk("err_wr_err", {31'd0, e}, 32'd1);
        rd("err_status", 32'h4, 32'h0000_1007);
        for (int i = 1; i < 16; i++) begin
            rd($sformatf("sim_pop%0d", i), 32'h0, 32'hA0 + 32'(i));
        end
        rd("sim_pop_ee", 32'h0, 32'h0000_00EE);
        do_reset();

        // ---------------- Asynchronous reset mid-transfer ----------------
        wr("ar_en", 32'h8, 32'h1);
        irq_permitted = 1'b1;
        rx_byte(8'h5A);
        for (int i = 1; i <= 6; i++) begin
            wr($sformatf("ar_wr%0d", i), 32'h0, 32'(i));
        end
        @(negedge clk_bus);
        chk("ar_tx_data", {24'd0, tx_data}, 32'h01);
        chk("ar_irq_before", {31'd0, irq}, 32'd1);
        @(negedge clk_bus);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h4; sel_i = 4'hF;
        @(posedge clk_bus);
        #1;
        $display("txn we=0 adr=00000004 before reset -> ack=%0d err=%0d rdat=%h", ack_o, err_o, dat_o);
        chk("ar_status_ack", {31'd0, ack_o}, 32'd1);
        chk("ar_status", dat_o, 32'h0005_0103);
        cyc_i = 1'b0; stb_i = 1'b0;
        #1 rst_bus_n = 1'b0;
        #1;
        chk("ar_ack",      {31'd0, ack_o},    32'd0);
        chk("ar_err",      {31'd0, err_o},    32'd0);
        chk("ar_dat",      dat_o,             32'd0);
        chk("ar_tx_start", {31'd0, tx_start}, 32'd0);
        chk("ar_tx_data0", {24'd0, tx_data},  32'd0);
        chk("ar_rx_clear", {31'd0, rx_clear}, 32'd0);
        chk("ar_irq",      {31'd0, irq},      32'd0);
        repeat (2) @(negedge clk_bus);
        rst_bus_n = 1'b1;
        rd("ar_status_after", 32'h4, 32'h0000_0006);
        rd("ar_thresh_after", 32'hC, 32'h1);
        rd("ar_en_after", 32'h8, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_uart_fifo_slave.md
# wb_uart_fifo_slave

Wishbone pipelined slave that puts a byte-level UART transmitter/receiver pair on the system bus. It buffers both directions in parametrised FIFOs and exposes data, status, interrupt-enable and RX-threshold registers. It raises a level interrupt toward the PLIC serial channel only when the PLIC grants permission. It succeeds the single-byte serial slave and shares the `clk_bus` domain with the UART byte modules.

## Interface
- `RX_AW`, 4: log2 of RX FIFO depth (depth 16).
- `TX_AW`, 4: log2 of TX FIFO depth (depth 16).
- `clk_bus` input 1: bus clock; the only clock.
- `rst_bus_n` input 1: reset, asynchronous assert, active-low.
- `adr_i` input 32: byte address; bits [3:2] select the register, bits [1:0] must be 0.
- `dat_i` input 32: write data.
- `dat_o` output 32: read data, valid with `ack_o`.
- `sel_i` input 4: byte selects; writes act only when `sel_i[0]=1`, otherwise acked with no effect.
- `cyc_i`, `stb_i`, `we_i` input 1 each: Wishbone cycle, strobe and write.
- `ack_o`, `err_o` output 1 each: completion and error.
- `rty_o`, `stall_o` output 1 each: tied to 0.
- `tx_data` output 8: byte to the transmitter.
- `tx_start` output 1: one-cycle start pulse.
- `tx_busy` input 1: transmitter busy.
- `rx_data` input 8: received byte.
- `rx_ready` input 1: received byte valid.
- `rx_clear` output 1: acknowledges `rx_ready`.
- `irq` output 1: interrupt request.
- `irq_permitted` input 1: PLIC permission.

## Operation
- **Registers**, selected by `adr_i[3:2]`:
  - 0 DATA.
    - Read pops the RX head and returns it as `{24'b0, byte}`. An empty FIFO returns 0 and does not pop.
    - Write pushes `dat_i[7:0]` to TX. A full FIFO drops the byte and sets `tx_ovf`.
  - 1 STATUS, read layout:
    - [0] RX non-empty; [1] TX not full; [2] TX empty and FSM IDLE.
    - [3] `rx_ovr`, sticky; [4] `tx_ovf`, sticky.
    - [15:8] RX count, zero-extended; [23:16] TX count.
    - Writing 1 to bit 3 or bit 4 clears that flag.
  - 2 IRQ_EN: [0] RX-threshold enable, [1] TX-empty enable; reads back, other bits read 0.
  - 3 RX_THRESH: [RX_AW:0] threshold, reset value 1.
- **Error:** `adr_i[1:0]≠0` returns `err_o` instead of `ack_o`, with no side effect.
- **FIFOs:**
  - Circular buffers; read/write pointers wrap modulo depth; counts are RX_AW+1 / TX_AW+1 bits.
  - A push is accepted when not full, or when a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
- **RX path:**
  - `rx_ready=1` while `rx_clear` is low: push `rx_data` and pulse `rx_clear` the next cycle.
  - If the push is refused, the byte is dropped, `rx_ovr` is set and `rx_clear` still pulses.
- **TX FSM:**
  - IDLE: if TX is non-empty and `tx_busy=0`, pop the head into the `tx_data` register and go to START.
  - START: `tx_start=1` for one cycle; go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy=1`, then go to WAIT_LO.
  - WAIT_LO: wait for `tx_busy=0`, then go to IDLE.
- **Interrupt:** `irq` is registered and equals `irq_permitted & ((en[0] & rx_count ≥ thresh) | (en[1] & tx_idle_empty))`.
  - A threshold of 0 with `en[0]=1` makes the RX term always true.
- **Reset** (also mid-operation):
  - FIFOs are flushed and flags cleared; IRQ_EN=0 and RX_THRESH=1.
  - FSM returns to IDLE; a byte already in the transmitter completes externally.

## Timing
- **Reset values:** `ack_o`=0, `err_o`=0, `dat_o`=0, `tx_start`=0, `tx_data`=0, `rx_clear`=0, `irq`=0.
- **Bus handshake:**
  - A request is accepted every cycle in which `cyc_i&stb_i=1`; `stall_o` is always 0.
  - `ack_o`/`err_o` and `dat_o` are registered, asserted exactly 1 cycle after acceptance, and last 1 cycle.
  - Back-to-back requests get back-to-back acks.
- **Side-effect timing:** pops, pushes and flag clears take effect at the accepting edge; STATUS reads sample pre-edge state.
- **`cyc_i` deassertion:** dropping `cyc_i` between accept and ack does not cancel side effects; the ack is still driven.
- **Latencies:**
  - TX write accept to `tx_start` is at least 2 cycles (push edge, IDLE pop edge, START).
  - `rx_ready` to RX count increment: 1 edge.
  - FIFO change to `irq` update: 1 cycle.

## Test plan
- **Loopback:** write DATA 0x41, 0x42 → `tx_start` pulses twice with `tx_data` 0x41 then 0x42, each only after `tx_busy` completes a high-low cycle; STATUS[2]=1 at the end.
- **RX overflow:** drive 17 `rx_ready` bytes 0x00..0x10 with no reads → STATUS[15:8]=16 and [3]=1; 16 DATA reads return 0x00..0x0F; a 17th read returns 0 and does not pop.
- **TX overflow:** hold `tx_busy=1` and write 18 bytes → one byte is in the FSM, 16 are in the FIFO, STATUS[4]=1; writing STATUS 0x10 clears bit 4.
- **Interrupt gating:** set RX_THRESH=3 and IRQ_EN=1, push 3 bytes → `irq`=1 only while `irq_permitted`=1; one DATA read drops `irq` the cycle after the ack.
- **Simultaneous events and error:**
  - RX full with `rx_ready` in the same cycle as a DATA read → count stays 16, `rx_ovr` stays 0.
  - Access with `adr_i`=0x2 → `err_o`=1, `ack_o`=0, no state change.
- **Async reset mid-transfer:** assert `rst_bus_n`=0 in WAIT_HI with 5 bytes queued → all outputs 0 immediately, counts 0, RX_THRESH reads 1 after release.
